// File: rtl/fetchq_pkg.sv
// Shared types and constants for the 2-entry fetch queue.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fetchq_pkg;

  localparam int unsigned DEPTH    = 2;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  // One queued fetch: instruction word, PC+8, address fault and delay-slot flag.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcadd8;
    logic        exc;
    logic        bd;
  } entry_t;

  // Occupancy states; the encoding doubles as the count output.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/fetchq_entry_mem.sv
// Two-entry register storage for the fetch queue: one write port, one read port.
// Latency: write lands on the next rising edge; read is combinational.
// Backpressure: none here; the controller decides when a write happens.
module fetchq_entry_mem
  import fetchq_pkg::*;
(
  input  logic   clk,
  input  logic   wr_en,
  input  logic   wr_ptr,
  input  entry_t wr_entry,
  input  logic   rd_ptr,
  output entry_t rd_entry
);

  entry_t mem [DEPTH];

  // Data registers only change on an accepted push, so a stall holds them stable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  assign rd_entry = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode 2-entry queue with flush; optional fault squash via FETCHQ_EXC_SQUASH_EN.
// Latency: push visible at the head one cycle later; head fields read combinationally.
// Backpressure: in_ready drops when FULL regardless of out_ready; no push into FULL.
module fetch_queue
  import fetchq_pkg::*;
#(
  parameter logic [31:0] PC_BASE  = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pcadd8,
  input  logic        in_exc,
  input  logic        in_bd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pcadd8,
  output logic        out_exc,
  output logic        out_bd,
  output logic [4:0]  out_exccode,
  output logic [1:0]  count
);

`ifdef FETCHQ_EXC_SQUASH_EN
  localparam bit SQUASH_EN = 1'b1;
`else
  localparam bit SQUASH_EN = 1'b0;
`endif

  // Fetch addresses are word aligned, so the PC base must be too.
  if (PC_BASE[1:0] != 2'b00) begin : g_pc_base_check
    $error("fetch_queue: PC_BASE must be word aligned");
  end

  state_t state, state_nxt;
  logic   wr_ptr, wr_ptr_nxt;
  logic   rd_ptr, rd_ptr_nxt;
  logic   push, pop, mem_wr_en;
  entry_t wr_entry, head;

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = state;

  // Faulting fetches optionally carry a NOP so decode never sees a garbage word.
  assign wr_entry = '{
    instr:  (SQUASH_EN && in_exc) ? NOP_WORD : in_instr,
    pcadd8: in_pcadd8,
    exc:    in_exc,
    bd:     in_bd
  };

  fetchq_entry_mem u_mem (
    .clk      (clk),
    .wr_en    (mem_wr_en),
    .wr_ptr   (wr_ptr),
    .wr_entry (wr_entry),
    .rd_ptr   (rd_ptr),
    .rd_entry (head)
  );

  // Occupancy state and pointers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // Next state: flush drops the same-cycle input and empties the queue; else push/pop.
  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    mem_wr_en  = 1'b0;
    if (flush) begin
      state_nxt  = ST_EMPTY;
      wr_ptr_nxt = 1'b0;
      rd_ptr_nxt = 1'b0;
    end else begin
      mem_wr_en = push & ~reset;
      if (push) wr_ptr_nxt = ~wr_ptr;
      if (pop)  rd_ptr_nxt = ~rd_ptr;
      case (state)
        ST_EMPTY: if (push) state_nxt = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_nxt = ST_FULL;
          else if (pop && !push) state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (pop) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  assign out_instr   = out_valid ? head.instr : 32'd0;
  assign out_pcadd8  = out_valid ? head.pcadd8 : 32'd0;
  assign out_pc      = out_valid ? (head.pcadd8 - 32'd8) : 32'd0;
  assign out_exc     = out_valid & head.exc;
  assign out_bd      = out_valid & head.bd;
  assign out_exccode = (out_valid && SQUASH_EN && head.exc) ? EXC_ADEL : 5'd0;

endmodule
